tx_frame_scheduler: RTL and testbench
=====================================

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 1024, meaning circular buffer capacity in bytes.
REQ-002 SHALL have parameter MAX_LEN, default 1000, meaning largest accepted payload length in bytes, with MAX_LEN+2 <= BUF_DEPTH.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning idle cycles tolerated between payload bytes.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset that is asynchronous and active-high.
REQ-006 SHALL have, for requester x in {a,b}: i_req_x in 1 (frame request), i_len_x in 16 (payload length), i_data_x in 8, i_valid_x in 1, o_ready_x out 1, o_grant_x out 1, o_done_x out 1 (one-cycle pulse), o_err_x out 1 (qualifies done).
REQ-007 SHALL have port i_buf_size, input, 16, meaning bytes currently held in the transmitter buffer.
REQ-008 SHALL have transmitter-side outputs: o_data out 8, o_data_we out 1, o_push_write_index out 1, o_pop_write_index out 1, o_push_frame out 1, all single-cycle strobes except o_data.
REQ-009 SHALL have port o_busy, output, 1, high when the FSM is not in IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, CHECK, MARK, LEN0, LEN1, DATA, COMMIT, ABORT, REJECT.
REQ-011 SHALL, in IDLE, grant round-robin between requesters with i_req high; priority goes to the requester not served last, and requester a wins after reset; latch i_len_x; assert o_grant_x from the following cycle until return to IDLE; next state CHECK.
REQ-012 SHALL, in CHECK, go to REJECT if the latched length is 0 or greater than MAX_LEN.
REQ-013 SHALL, in CHECK, otherwise wait until BUF_DEPTH - i_buf_size >= length+2 (17-bit arithmetic, no wrap), then go to MARK.
REQ-014 SHALL, in MARK, pulse o_push_write_index for one cycle, then go to LEN0.
REQ-015 SHALL, in LEN0 and LEN1, write length[7:0] and then length[15:8] respectively, one cycle each, with o_data_we=1.
REQ-016 SHALL, in DATA, drive o_ready_x=1 for the granted requester only; each cycle with i_valid_x && o_ready_x, write i_data_x the same cycle (o_data_we=1, zero latency).
REQ-017 SHALL count payload bytes from length down; after the last byte o_ready_x drops the next cycle and the FSM goes to COMMIT.
REQ-018 SHALL, in COMMIT, pulse o_push_frame and o_done_x (o_err_x=0), then go to IDLE.
REQ-019 SHALL, in DATA, count consecutive cycles without a transfer; reaching TIMEOUT goes to ABORT.
REQ-020 SHALL, in DATA, go to ABORT if i_req_x drops.
REQ-021 SHALL, in ABORT, pulse o_pop_write_index and o_done_x with o_err_x=1, then go to IDLE; no o_push_frame is issued.
REQ-022 SHALL, in REJECT, pulse o_done_x with o_err_x=1 without touching the buffer, then go to IDLE.
REQ-023 SHALL never assert o_push_write_index, o_pop_write_index, o_push_frame or o_data_we in the same cycle as one another.
REQ-024 SHALL evaluate simultaneous requests only in IDLE; a request arriving mid-frame waits.
REQ-025 SHALL treat IDLE as a one-cycle minimum between frames, so back-to-back frames alternate requesters.
REQ-026 SHALL force an undefined state to IDLE.

Reset
REQ-027 SHALL, while i_rst=1, hold state IDLE, all strobes/o_ready/o_grant/o_done/o_err/o_busy 0, o_data 0, counters 0, and round-robin pointer favouring a.
REQ-028 SHALL, on reset mid-frame, not emit o_pop_write_index; the transmitter is reset alongside.

Structure
REQ-029 SHALL place the state encoding (4-bit localparams) and default BUF_DEPTH/MAX_LEN/TIMEOUT in shared package tx_pkg.
REQ-030 SHALL use one sub-module, rr_arbiter2 (2-way round-robin with registered last-grant pointer).

Verification
REQ-031 SHALL verify: a requests len=3, bytes 11,22,33, i_buf_size=0 -> writes 03,00,11,22,33; one push_write_index before them, one push_frame after; done_a, err_a=0.
REQ-032 SHALL verify: a and b request together after reset -> a granted first; b granted on the next frame; a re-requesting twice alternates with b.
REQ-033 SHALL verify: len=0 and len=1001 -> done with err=1; no buffer strobes.
REQ-034 SHALL verify: BUF_DEPTH=1024, i_buf_size=1020, len=3 -> waits in CHECK; i_buf_size drops to 1019 -> MARK proceeds.
REQ-035 SHALL verify: len=4, valid stops after 2 bytes for 255 cycles -> one o_pop_write_index, err=1, no push_frame.
REQ-036 SHALL verify: i_rst pulsed during DATA -> all outputs 0 same cycle; the next request is served cleanly.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the transmit frame scheduler: FSM encoding, default sizing, buffer helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tx_pkg;

   // Default sizing. MAX_LEN + 2 must fit in BUF_DEPTH because the two length bytes precede the payload.
   localparam int TX_BUF_DEPTH = 1024;
   localparam int TX_MAX_LEN   = 1000;
   localparam int TX_TIMEOUT   = 255;

   // FSM encoding, kept as plain 4-bit constants so older tooling can decode state dumps.
   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_CHECK  = 4'd1;
   localparam logic [3:0] ST_MARK   = 4'd2;
   localparam logic [3:0] ST_LEN0   = 4'd3;
   localparam logic [3:0] ST_LEN1   = 4'd4;
   localparam logic [3:0] ST_DATA   = 4'd5;
   localparam logic [3:0] ST_COMMIT = 4'd6;
   localparam logic [3:0] ST_ABORT  = 4'd7;
   localparam logic [3:0] ST_REJECT = 4'd8;

   // Everything the scheduler presents to the transmitter buffer in one cycle.
   typedef struct packed {
      logic       push_write_index;
      logic       pop_write_index;
      logic       push_frame;
      logic       data_we;
      logic [7:0] data;
   } tx_side_t;

   // A payload length is acceptable when it is non-zero and no larger than max_len.
   function automatic logic len_ok(input logic [15:0] len, input int max_len);
      return (len != 16'd0) && (32'(len) <= 32'(max_len));
   endfunction

   // True when the buffer has room for the two length bytes plus the payload.
   // Done as occupancy + need <= depth in 18 bits so an over-reported occupancy never wraps into "room".
   function automatic logic space_ok(input logic [15:0] buf_size, input logic [15:0] len, input int depth);
      logic [17:0] need;
      need = 18'(buf_size) + 18'(len) + 18'd2;
      return need <= 18'(depth);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: offers the requester not served last, a first after reset.
// Latency: grant is combinational from req; the last-served pointer updates on the accepting edge.
// Backpressure: the offer is held until accept; with no accept the pointer never moves.
module rr_arbiter2
   import tx_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   // 1 when requester b was served most recently; reset to 1 so that a wins first.
   logic last_b;

   // Offer a single grant: a lone requester always wins, a tie goes to whoever was not served last.
   always_comb begin
      gnt = 2'b00;
      if (req[0] && req[1]) begin
         gnt = last_b ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

   // Remember which side was served once the offer is taken.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_b <= 1'b1;
      end else if (accept && (gnt != 2'b00)) begin
         last_b <= gnt[1];
      end
   end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Two-requester frame scheduler: arbitrates, reserves buffer room, writes 2 length bytes + payload, commits or aborts.
// Latency: grant one cycle after arbitration in IDLE; accepted payload bytes appear on o_data the same cycle.
// Backpressure: holds in CHECK until the buffer has room; o_ready_x only in DATA; a stall of TIMEOUT cycles aborts.
module tx_frame_scheduler
   import tx_pkg::*;
#(
   parameter int BUF_DEPTH = TX_BUF_DEPTH,
   parameter int MAX_LEN   = TX_MAX_LEN,
   parameter int TIMEOUT   = TX_TIMEOUT
)(
   input  logic        i_clk,
   input  logic        i_rst,
   // requester a
   input  logic        i_req_a,
   input  logic [15:0] i_len_a,
   input  logic [7:0]  i_data_a,
   input  logic        i_valid_a,
   output logic        o_ready_a,
   output logic        o_grant_a,
   output logic        o_done_a,
   output logic        o_err_a,
   // requester b
   input  logic        i_req_b,
   input  logic [15:0] i_len_b,
   input  logic [7:0]  i_data_b,
   input  logic        i_valid_b,
   output logic        o_ready_b,
   output logic        o_grant_b,
   output logic        o_done_b,
   output logic        o_err_b,
   // transmitter buffer side
   input  logic [15:0] i_buf_size,
   output logic [7:0]  o_data,
   output logic        o_data_we,
   output logic        o_push_write_index,
   output logic        o_pop_write_index,
   output logic        o_push_frame,
   output logic        o_busy
);

   logic [3:0]  state;
   logic [3:0]  state_nxt;
   logic        sel_b;       // requester owning the current frame (1 = b)
   logic [15:0] len_q;       // latched payload length
   logic [15:0] remain_q;    // payload bytes still to come
   logic [15:0] idle_q;      // consecutive DATA cycles without a transfer
   logic [1:0]  arb_gnt;
   logic        arb_accept;
   logic        cur_req;
   logic        cur_valid;
   logic [7:0]  cur_data;
   logic        xfer;
   logic        in_done;
   logic        in_err;
   tx_side_t    tx;

   // The arbiter is only consulted in IDLE, so a request arriving mid-frame simply waits.
   assign arb_accept = (state == ST_IDLE);

   rr_arbiter2 u_arb (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .req    ({i_req_b, i_req_a}),
      .accept (arb_accept),
      .gnt    (arb_gnt)
   );

   // Signals of whichever requester owns the frame.
   assign cur_req   = sel_b ? i_req_b   : i_req_a;
   assign cur_valid = sel_b ? i_valid_b : i_valid_a;
   assign cur_data  = sel_b ? i_data_b  : i_data_a;

   // o_ready is simply "in DATA", so a transfer is the owner's valid during DATA.
   assign xfer = (state == ST_DATA) && cur_valid;

   // Next-state decision for the frame sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (arb_gnt != 2'b00) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (!len_ok(len_q, MAX_LEN))                   state_nxt = ST_REJECT;
            else if (space_ok(i_buf_size, len_q, BUF_DEPTH)) state_nxt = ST_MARK;
         end
         ST_MARK:   state_nxt = ST_LEN0;
         ST_LEN0:   state_nxt = ST_LEN1;
         ST_LEN1:   state_nxt = ST_DATA;
         ST_DATA: begin
            // A withdrawn request wins over everything else, including a final byte in the same cycle.
            if (!cur_req)                                   state_nxt = ST_ABORT;
            else if (xfer && (remain_q == 16'd1))           state_nxt = ST_COMMIT;
            else if (!xfer && (idle_q == 16'(TIMEOUT - 1))) state_nxt = ST_ABORT;
         end
         ST_COMMIT: state_nxt = ST_IDLE;
         ST_ABORT:  state_nxt = ST_IDLE;
         ST_REJECT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture frame owner and its length at the moment of arbitration.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sel_b <= 1'b0;
         len_q <= 16'd0;
      end else if ((state == ST_IDLE) && (arb_gnt != 2'b00)) begin
         sel_b <= arb_gnt[1];
         len_q <= arb_gnt[1] ? i_len_b : i_len_a;
      end
   end

   // Payload down-counter and stall counter; both restart as the frame enters DATA.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         remain_q <= 16'd0;
         idle_q   <= 16'd0;
      end else if (state == ST_LEN1) begin
         remain_q <= len_q;
         idle_q   <= 16'd0;
      end else if (state == ST_DATA) begin
         if (xfer) begin
            remain_q <= remain_q - 16'd1;
            idle_q   <= 16'd0;
         end else begin
            idle_q   <= idle_q + 16'd1;
         end
      end else begin
         idle_q <= 16'd0;
      end
   end

   // Transmitter strobes: one per state, so they can never overlap; o_data is zero unless writing.
   always_comb begin
      tx = '0;
      case (state)
         ST_MARK: tx.push_write_index = 1'b1;
         ST_LEN0: begin
            tx.data_we = 1'b1;
            tx.data    = len_q[7:0];
         end
         ST_LEN1: begin
            tx.data_we = 1'b1;
            tx.data    = len_q[15:8];
         end
         ST_DATA: begin
            if (xfer) begin
               tx.data_we = 1'b1;
               tx.data    = cur_data;
            end
         end
         ST_COMMIT: tx.push_frame      = 1'b1;
         ST_ABORT:  tx.pop_write_index = 1'b1;
         default:   tx = '0;
      endcase
   end

   assign o_data             = tx.data;
   assign o_data_we          = tx.data_we;
   assign o_push_write_index = tx.push_write_index;
   assign o_pop_write_index  = tx.pop_write_index;
   assign o_push_frame       = tx.push_frame;

   // Requester-facing status, all decoded from the registered state.
   assign in_done   = (state == ST_COMMIT) || (state == ST_ABORT) || (state == ST_REJECT);
   assign in_err    = (state == ST_ABORT)  || (state == ST_REJECT);
   assign o_busy    = (state != ST_IDLE);
   assign o_grant_a = o_busy && !sel_b;
   assign o_grant_b = o_busy &&  sel_b;
   assign o_ready_a = (state == ST_DATA) && !sel_b;
   assign o_ready_b = (state == ST_DATA) &&  sel_b;
   assign o_done_a  = in_done && !sel_b;
   assign o_done_b  = in_done &&  sel_b;
   assign o_err_a   = in_err  && !sel_b;
   assign o_err_b   = in_err  &&  sel_b;

   // Buffer strobes are mutually exclusive and done is a single-cycle pulse.
   a_strobe_excl: assert property (@(posedge i_clk) disable iff (i_rst)
      $onehot0({o_push_write_index, o_pop_write_index, o_push_frame, o_data_we}));
   a_done_pulse: assert property (@(posedge i_clk) disable iff (i_rst)
      (o_done_a || o_done_b) |=> !(o_done_a || o_done_b));

endmodule

// File: tb/tb_tx_frame_scheduler.sv
module tb_tx_frame_scheduler;
   import tx_pkg::*;

   localparam int MAX_LEN = 1000;
   localparam int TIMEOUT = 255;
   localparam int M_NORMAL = 0;
   localparam int M_STALL  = 1;
   localparam int M_DROP   = 2;
   localparam int M_RESET  = 3;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_req_a = 0, i_valid_a = 0, i_req_b = 0, i_valid_b = 0;
   logic [15:0] i_len_a = 0, i_len_b = 0, i_buf_size = 0;
   logic [7:0]  i_data_a = 0, i_data_b = 0;
   logic        o_ready_a, o_grant_a, o_done_a, o_err_a;
   logic        o_ready_b, o_grant_b, o_done_b, o_err_b;
   logic [7:0]  o_data;
   logic        o_data_we, o_push_write_index, o_pop_write_index, o_push_frame, o_busy;

   always #5 i_clk = ~i_clk;

   tx_frame_scheduler dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_a(i_req_a), .i_len_a(i_len_a), .i_data_a(i_data_a), .i_valid_a(i_valid_a),
      .o_ready_a(o_ready_a), .o_grant_a(o_grant_a), .o_done_a(o_done_a), .o_err_a(o_err_a),
      .i_req_b(i_req_b), .i_len_b(i_len_b), .i_data_b(i_data_b), .i_valid_b(i_valid_b),
      .o_ready_b(o_ready_b), .o_grant_b(o_grant_b), .o_done_b(o_done_b), .o_err_b(o_err_b),
      .i_buf_size(i_buf_size), .o_data(o_data), .o_data_we(o_data_we),
      .o_push_write_index(o_push_write_index), .o_pop_write_index(o_pop_write_index),
      .o_push_frame(o_push_frame), .o_busy(o_busy)
   );

   // One observable transmitter/requester event.
   typedef struct packed {
      logic       push_idx;
      logic       pop_idx;
      logic       push_frame;
      logic       we;
      logic [7:0] data;
      logic       done_a, done_b, err_a, err_b, grant_a, grant_b;
   } ev_t;

   typedef struct {
      int          id;
      logic        side;
      logic [15:0] len;
      int          mode;
      int          cut;
      int          pat;
   } frame_t;

   ev_t    exp_q[$];
   frame_t qa[$], qb[$];
   int     checks = 0, errors = 0;
   int     push_idx_cnt = 0, cyc = 0, last_we_cyc = 0, pop_cyc = 0, next_id = 1;
   logic   last_b = 1'b1;  // reference arbiter: requester served last

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({o_ready_a, o_grant_a, o_done_a, o_err_a, o_ready_b, o_grant_b, o_done_b, o_err_b,
                  o_data, o_data_we, o_push_write_index, o_pop_write_index, o_push_frame, o_busy});
   endfunction

   function automatic logic [7:0] byte_of(frame_t f, int i);
      if (f.pat == 1) return 8'((i + 1) * 11);
      return 8'(f.id * 37 + i * 13 + 5);
   endfunction

   function automatic ev_t mk_ev(logic side);
      ev_t e;
      e = '0;
      e.grant_a = !side;
      e.grant_b = side;
      return e;
   endfunction

   // Reference model: the event stream a frame must produce, from the frame's own description.
   task automatic expect_frame(frame_t f);
      ev_t e;
      int  n;
      if (f.len == 16'd0 || int'(f.len) > MAX_LEN) begin
         e = mk_ev(f.side);
         e.done_a = !f.side; e.err_a = !f.side;
         e.done_b = f.side;  e.err_b = f.side;
         exp_q.push_back(e);
         return;
      end
      e = mk_ev(f.side); e.push_idx = 1; exp_q.push_back(e);
      e = mk_ev(f.side); e.we = 1; e.data = f.len[7:0];  exp_q.push_back(e);
      e = mk_ev(f.side); e.we = 1; e.data = f.len[15:8]; exp_q.push_back(e);
      n = (f.mode == M_NORMAL) ? int'(f.len) : f.cut;
      for (int i = 0; i < n; i++) begin
         e = mk_ev(f.side); e.we = 1; e.data = byte_of(f, i); exp_q.push_back(e);
      end
      if (f.mode == M_RESET) return;
      e = mk_ev(f.side);
      e.done_a = !f.side; e.done_b = f.side;
      if (f.mode == M_NORMAL) begin
         e.push_frame = 1;
      end else begin
         e.pop_idx = 1; e.err_a = !f.side; e.err_b = f.side;
      end
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: every cycle with a strobe or done must match the next expected event.
   always @(negedge i_clk) begin : monitor
      ev_t o;
      ev_t e;
      if (!i_rst) begin
         o = '0;
         o.push_idx   = o_push_write_index;
         o.pop_idx    = o_pop_write_index;
         o.push_frame = o_push_frame;
         o.we         = o_data_we;
         o.data       = o_data_we ? o_data : 8'h00;
         o.done_a     = o_done_a;
         o.done_b     = o_done_b;
         o.err_a      = o_err_a & o_done_a;
         o.err_b      = o_err_b & o_done_b;
         o.grant_a    = o_grant_a;
         o.grant_b    = o_grant_b;
         if (o.push_idx || o.pop_idx || o.push_frame || o.we || o.done_a || o.done_b) begin
            if (o.push_idx) push_idx_cnt++;
            if (o.we) last_we_cyc = cyc;
            if (o.pop_idx) pop_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got %h expected no event", o);
            end else begin
               e = exp_q.pop_front();
               if (o !== e) begin
                  errors++;
                  $display("FAIL sb_event: got %h expected %h", o, e);
               end
            end
         end
      end
   end

   task automatic drive(logic side, logic v, logic [7:0] d);
      if (side) begin i_valid_b = v; i_data_b = d; end
      else      begin i_valid_a = v; i_data_a = d; end
   endtask

   // Feed one frame once its requester is granted; returns after done (or a reset injection).
   task automatic serve(frame_t f);
      int   sent;
      int   limit;
      logic got;
      sent  = 0;
      limit = (f.mode == M_NORMAL) ? int'(f.len) : f.cut;
      got   = 0;
      for (int c = 0; c < 300 && !got; c++) begin
         @(posedge i_clk); #1;
         got = f.side ? o_grant_b : o_grant_a;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL grant_wait: got no grant for side %0d within 300 cycles", f.side);
         return;
      end
      for (int c = 0; c < 4000; c++) begin
         if (f.side ? o_done_b : o_done_a) begin
            drive(f.side, 0, 8'h00);
            return;
         end
         if (f.side ? o_ready_b : o_ready_a) begin
            if (f.mode == M_RESET && sent == limit) begin
               drive(f.side, 1, 8'hA5);
               i_rst = 1; #1;
               check("rst_mid_outputs", all_outs(), 0);
               check("rst_mid_we", 32'(o_data_we), 0);
               check("rst_mid_busy", 32'(o_busy), 0);
               repeat (2) @(posedge i_clk); #1;
               check("rst_hold_outputs", all_outs(), 0);
               drive(f.side, 0, 8'h00);
               i_req_a = 0; i_req_b = 0;
               i_rst = 0;
               last_b = 1'b1;
               check("rst_sb_drained", 32'(exp_q.size()), 0);
               return;
            end else if (f.mode == M_DROP && sent == limit) begin
               drive(f.side, 0, 8'h00);
               if (f.side) i_req_b = 0; else i_req_a = 0;
            end else if (sent < limit && (f.mode != M_NORMAL || $urandom_range(0, 3) != 0)) begin
               drive(f.side, 1, byte_of(f, sent));
               sent++;
            end else begin
               drive(f.side, 0, 8'h00);
            end
         end else begin
            drive(f.side, 0, 8'h00);
         end
         @(posedge i_clk); #1;
      end
      checks++; errors++;
      $display("FAIL done_wait: got no done for side %0d within 4000 cycles", f.side);
   endtask

   task automatic add_frame(logic side, int len, int mode, int cut, int pat);
      frame_t f;
      f.id = next_id; f.side = side; f.len = 16'(len); f.mode = mode; f.cut = cut; f.pat = pat;
      next_id++;
      if (side) qb.push_back(f); else qa.push_back(f);
   endtask

   // Requesters hold req while they have frames; the reference round-robin predicts each winner.
   task automatic run_batch();
      frame_t f;
      logic   s;
      while (qa.size() + qb.size() > 0) begin
         i_req_a = (qa.size() > 0);
         if (qa.size() > 0) i_len_a = qa[0].len;
         i_req_b = (qb.size() > 0);
         if (qb.size() > 0) i_len_b = qb[0].len;
         s = (qa.size() > 0 && qb.size() > 0) ? !last_b : (qb.size() > 0);
         last_b = s;
         if (s) f = qb.pop_front(); else f = qa.pop_front();
         expect_frame(f);
         serve(f);
      end
      i_req_a = 0; i_req_b = 0;
      drive(0, 0, 8'h00); drive(1, 0, 8'h00);
      repeat (2) @(posedge i_clk); #1;
   endtask

   initial begin : watchdog
      repeat (90000) @(posedge i_clk);
      $display("FAIL watchdog: got no end of test within 90000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      frame_t f;
      int     c0;
      int     len;
      int     r;
      #2 i_rst = 1;
      i_req_a = 1; i_len_a = 16'd5; i_req_b = 1; i_len_b = 16'd6;
      repeat (3) @(posedge i_clk); #1;
      check("reset_outputs", all_outs(), 0);
      check("reset_busy", 32'(o_busy), 0);
      check("reset_grant", 32'({o_grant_a, o_grant_b}), 0);
      i_req_a = 0; i_req_b = 0;
      i_rst = 0;
      @(posedge i_clk); #1;
      check("idle_outputs", all_outs(), 0);

      // Simultaneous requests after reset: a first, then alternating.
      add_frame(0, 4, M_NORMAL, 0, 0); add_frame(0, 5, M_NORMAL, 0, 0); add_frame(0, 6, M_NORMAL, 0, 0);
      add_frame(1, 3, M_NORMAL, 0, 0); add_frame(1, 7, M_NORMAL, 0, 0);
      run_batch();

      // Bytes 11,22,33 from a with an empty buffer.
      add_frame(0, 3, M_NORMAL, 0, 1);
      run_batch();

      // Length boundaries: 1000 accepted, 0 and 1001 rejected.
      add_frame(0, 0, M_NORMAL, 0, 0); add_frame(0, 1001, M_NORMAL, 0, 0);
      add_frame(1, 1000, M_NORMAL, 0, 0);
      run_batch();

      // Buffer room: 1020 of 1024 used blocks a 3-byte frame; 1019 lets it through.
      i_buf_size = 16'd1020;
      f.id = next_id; f.side = 0; f.len = 16'd3; f.mode = M_NORMAL; f.cut = 0; f.pat = 0;
      next_id++;
      i_req_a = 1; i_len_a = 16'd3;
      last_b = 1'b0;
      expect_frame(f);
      c0 = push_idx_cnt;
      fork
         serve(f);
         begin
            repeat (40) @(posedge i_clk); #2;
            check("space_wait_no_mark", 32'(push_idx_cnt), 32'(c0));
            check("space_wait_busy", 32'(o_busy), 1);
            check("space_wait_ready", 32'(o_ready_a), 0);
            i_buf_size = 16'd1019;
         end
      join
      check("space_mark_once", 32'(push_idx_cnt), 32'(c0 + 1));
      i_req_a = 0;
      i_buf_size = 16'd0;
      repeat (2) @(posedge i_clk); #1;

      // Stall after 2 of 4 bytes: abort after the timeout.
      add_frame(0, 4, M_STALL, 2, 0);
      run_batch();
      check("timeout_gap", 32'((pop_cyc - last_we_cyc >= TIMEOUT) && (pop_cyc - last_we_cyc <= TIMEOUT + 2)), 1);

      // Randomized mix of sides, lengths, rejects and withdrawn requests.
      i_buf_size = 16'($urandom_range(0, 20));
      for (int k = 0; k < 24; k++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      len = 0;
         else if (r == 1) len = 1001 + int'($urandom_range(0, 500));
         else             len = int'($urandom_range(1, 16));
         if (len > 0 && $urandom_range(0, 5) == 0)
            add_frame(1'($urandom_range(0, 1)), len, M_DROP, int'($urandom_range(0, len - 1)), 0);
         else
            add_frame(1'($urandom_range(0, 1)), len, M_NORMAL, 0, 0);
      end
      run_batch();
      i_buf_size = 16'd0;

      // Reset during DATA, then clean service with the pointer back on a.
      add_frame(0, 8, M_RESET, 3, 0);
      run_batch();
      add_frame(0, 5, M_NORMAL, 0, 0); add_frame(1, 2, M_NORMAL, 0, 0);
      run_batch();

      repeat (5) @(posedge i_clk); #1;
      check("sb_drained", 32'(exp_q.size()), 0);
      check("end_idle", 32'(o_busy), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
